// File: rtl/axi_slv_arb_pkg.sv
// Shared types and helpers for the per-slave address arbiter and its order FIFO.
package axi_slv_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width for n entries, never below one bit.
  function automatic int bits_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Input is assumed one-hot (or zero); OR-ing indices gives the binary position.
  function automatic int oh2bin(input logic [7:0] oh);
    int b;
    b = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) b = b | i;
    end
    return b;
  endfunction

endpackage

// File: rtl/axi_slv_arb_fifo.sv
// Small order FIFO recording granted master indices; head entry is read straight from storage.
module axi_slv_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          full
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  // Pop on empty is dropped so the count cannot wrap below zero.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & valid;

  assign valid = (r_cnt != '0);
  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign data  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/axi_slv_arb.sv
// Per-slave AXI address-channel arbiter: round-robin grant held until the slave
// handshake, with accepted master indices logged in order for W-channel steering.
module axi_slv_arb
  import axi_slv_arb_pkg::*;
#(
  parameter int MSTRS     = 4,
  parameter int MSTR_BITS = bits_for(MSTRS),
  parameter int ORD_DEPTH = 4,
  parameter int ORD_BITS  = bits_for(ORD_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MSTRS-1:0]     req,
  input  logic                 s_aready,
  output logic                 s_avalid,
  output logic [MSTRS-1:0]     m_aready,
  output logic [MSTRS-1:0]     grant,
  output logic [MSTR_BITS-1:0] grant_idx,
  input  logic                 ord_pop,
  output logic                 ord_valid,
  output logic [MSTR_BITS-1:0] ord_idx,
  output logic                 ord_full
);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [MSTRS-1:0]     r_grant;
  logic [MSTRS-1:0]     w_grant_nxt;
  logic [MSTR_BITS-1:0] r_grant_idx;
  logic [MSTR_BITS-1:0] w_gidx_nxt;
  logic [MSTR_BITS-1:0] r_rr_ptr;
  logic [MSTR_BITS-1:0] w_rr_nxt;
  logic [MSTRS-1:0]     w_pick;
  logic                 w_push;

  // First requester at or above the pointer, wrapping modulo MSTRS.
  function automatic logic [MSTRS-1:0] rr_pick(input logic [MSTRS-1:0]     r,
                                               input logic [MSTR_BITS-1:0] ptr);
    logic [MSTRS-1:0]     oh;
    logic                 found;
    logic [MSTR_BITS-1:0] bidx;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < MSTRS; k++) begin
      bidx = MSTR_BITS'((int'(ptr) + k) % MSTRS);
      if (!found && r[bidx]) begin
        oh[bidx] = 1'b1;
        found    = 1'b1;
      end
    end
    return oh;
  endfunction

  assign w_pick = rr_pick(req, r_rr_ptr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_gidx_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

  // Once granted, only the slave handshake releases BUSY; req is not looked at.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_grant_idx;
    w_rr_nxt    = r_rr_ptr;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if ((|req) && !ord_full) begin
          w_grant_nxt = w_pick;
          w_gidx_nxt  = MSTR_BITS'(oh2bin(8'(w_pick)));
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (s_aready) begin
          w_push      = 1'b1;
          w_rr_nxt    = (r_grant_idx == MSTR_BITS'(MSTRS - 1)) ? '0 : r_grant_idx + MSTR_BITS'(1);
          w_grant_nxt = '0;
          w_gidx_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s_avalid  = (r_state == BUSY);
  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign m_aready  = r_grant & {MSTRS{s_aready}};

  axi_slv_arb_fifo #(
    .DEPTH (ORD_DEPTH),
    .AW    (ORD_BITS),
    .DW    (MSTR_BITS)
  ) u_ord_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (r_grant_idx),
    .pop       (ord_pop),
    .valid     (ord_valid),
    .data      (ord_idx),
    .full      (ord_full)
  );

endmodule

// File: tb/tb_axi_slv_arb.sv
// Bench for axi_slv_arb: directed scenarios plus a randomized run against a queue-based model.
module tb_axi_slv_arb;

  localparam int MSTRS = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       s_aready = 1'b0;
  logic       ord_pop = 1'b0;
  logic       s_avalid;
  logic [3:0] m_aready;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       ord_valid;
  logic [1:0] ord_idx;
  logic       ord_full;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding grant, a pointer and a queue of accepted masters.
  bit mdl_busy;
  int mdl_gnt;
  int mdl_ptr;
  int mdl_q[$];

  axi_slv_arb #(.MSTRS(4), .MSTR_BITS(2), .ORD_DEPTH(4), .ORD_BITS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .s_aready  (s_aready),
    .s_avalid  (s_avalid),
    .m_aready  (m_aready),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ord_pop   (ord_pop),
    .ord_valid (ord_valid),
    .ord_idx   (ord_idx),
    .ord_full  (ord_full)
  );

  always #5 clk = ~clk;

  a_req_held: assert property (@(posedge clk) disable iff (!reset) s_avalid |-> (|(grant & req)))
    else $error("granted request dropped before the slave handshake");

  function automatic int mdl_pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < MSTRS; k++) begin
      int idx;
      idx = (ptr + k) % MSTRS;
      if (((r >> idx) & 4'd1) != 4'd0) return idx;
    end
    return 0;
  endfunction

  task automatic model_reset();
    mdl_busy = 1'b0;
    mdl_gnt  = 0;
    mdl_ptr  = 0;
    mdl_q.delete();
  endtask

  task automatic model_edge();
    bit do_pop;
    bit do_push;
    int pushed;
    do_pop  = ord_pop && (mdl_q.size() > 0);
    do_push = 1'b0;
    pushed  = 0;
    if (!mdl_busy) begin
      if (req != 4'b0000 && mdl_q.size() < DEPTH) begin
        mdl_gnt  = mdl_pick(req, mdl_ptr);
        mdl_busy = 1'b1;
      end
    end else if (s_aready) begin
      do_push  = 1'b1;
      pushed   = mdl_gnt;
      mdl_ptr  = (mdl_gnt + 1) % MSTRS;
      mdl_busy = 1'b0;
    end
    if (do_pop) void'(mdl_q.pop_front());
    if (do_push) mdl_q.push_back(pushed);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    req      = 4'b0000;
    s_aready = 1'b0;
    ord_pop  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req   = 4'b1111;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (s_avalid !== 1'b0) begin n_fail++; $display("FAIL reset_avalid: got %b want 0", s_avalid); end
    n_checks++; if (ord_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ord_valid: got %b want 0", ord_valid); end
    n_checks++; if (ord_full !== 1'b0 || grant_idx !== 2'd0 || m_aready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_misc: full=%b gidx=%0d maready=%b want 0/0/0000", ord_full, grant_idx, m_aready);
    end
    reset = 1'b1;
    for (int c = 0; c < 2 && grant == 4'b0000; c++) cycle();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", grant); end
  endtask

  task automatic test_round_robin();
    int acc[$];
    int acc_cyc[$];
    int npop;
    int exp_ord[5];
    exp_ord = '{0, 1, 2, 3, 0};
    npop = 0;
    apply_reset();
    req      = 4'b1111;
    s_aready = 1'b1;
    for (int c = 0; c < 30 && acc.size() < 5; c++) begin
      ord_pop = (c % 2 == 1);
      #1;
      if (m_aready != 4'b0000) begin
        acc.push_back(int'(grant_idx));
        acc_cyc.push_back(c);
      end
      if (ord_pop && ord_valid && npop < 5) begin
        n_checks++; if (int'(ord_idx) != exp_ord[npop]) begin n_fail++; $display("FAIL rr_pop_idx%0d: got %0d want %0d", npop, ord_idx, exp_ord[npop]); end
        npop++;
      end
      cycle();
    end
    ord_pop = 1'b0;
    n_checks++; if (acc.size() != 5) begin n_fail++; $display("FAIL rr_accept_count: got %0d want 5", acc.size()); end
    for (int i = 0; i < acc.size() && i < 5; i++) begin
      n_checks++; if (acc[i] != exp_ord[i]) begin n_fail++; $display("FAIL rr_order%0d: got %0d want %0d", i, acc[i], exp_ord[i]); end
      if (i > 0) begin
        n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != 2) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d want 2", i, acc_cyc[i] - acc_cyc[i-1]); end
      end
    end
    n_checks++; if (npop != 4) begin n_fail++; $display("FAIL rr_pop_count: got %0d want 4", npop); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req      = 4'b0100;
    s_aready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (grant !== 4'b0100 || s_avalid !== 1'b1 || m_aready !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold%0d: grant=%b avalid=%b maready=%b want 0100/1/0000", i, grant, s_avalid, m_aready);
      end
      cycle();
    end
    s_aready = 1'b1;
    #1;
    n_checks++; if (m_aready !== 4'b0100) begin n_fail++; $display("FAIL bp_handshake_maready: got %b want 0100", m_aready); end
    n_checks++; if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL bp_grant_idx: got %0d want 2", grant_idx); end
    cycle();
    req      = 4'b0000;
    s_aready = 1'b0;
    #1;
    n_checks++; if (grant !== 4'b0000 || m_aready !== 4'b0000 || s_avalid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: grant=%b maready=%b avalid=%b want 0000/0000/0", grant, m_aready, s_avalid);
    end
    n_checks++; if (ord_valid !== 1'b1 || ord_idx !== 2'd2) begin n_fail++; $display("FAIL bp_ord: valid=%b idx=%0d want 1/2", ord_valid, ord_idx); end
  endtask

  task automatic test_fifo_full();
    int acc;
    int heads[5];
    heads = '{0, 1, 0, 1, 0};
    apply_reset();
    req      = 4'b0011;
    s_aready = 1'b1;
    acc      = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m_aready != 4'b0000) acc++;
      cycle();
    end
    n_checks++; if (acc != 4) begin n_fail++; $display("FAIL full_accepts: got %0d want 4", acc); end
    n_checks++; if (ord_full !== 1'b1 || grant !== 4'b0000 || s_avalid !== 1'b0) begin
      n_fail++; $display("FAIL full_stall: full=%b grant=%b avalid=%b want 1/0000/0", ord_full, grant, s_avalid);
    end
    ord_pop = 1'b1;
    #1;
    n_checks++; if (ord_idx !== 2'(heads[0])) begin n_fail++; $display("FAIL full_head0: got %0d want %0d", ord_idx, heads[0]); end
    cycle();
    ord_pop = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (m_aready != 4'b0000) acc++;
      cycle();
    end
    n_checks++; if (acc != 1 || ord_full !== 1'b1) begin n_fail++; $display("FAIL full_one_more: accepts=%0d full=%b want 1/1", acc, ord_full); end
    req     = 4'b0000;
    ord_pop = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      n_checks++; if (ord_valid !== 1'b1 || ord_idx !== 2'(heads[k])) begin
        n_fail++; $display("FAIL full_head%0d: valid=%b idx=%0d want 1/%0d", k, ord_valid, ord_idx, heads[k]);
      end
      cycle();
    end
    ord_pop = 1'b0;
    #1;
    n_checks++; if (ord_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", ord_valid); end
  endtask

  task automatic test_push_pop();
    int acc;
    int n;
    apply_reset();
    req      = 4'b0001;
    s_aready = 1'b1;
    acc      = 0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      #1;
      if (m_aready != 4'b0000) begin
        acc++;
        if (acc == 4) ord_pop = 1'b1;
      end
      cycle();
    end
    ord_pop  = 1'b0;
    req      = 4'b0000;
    s_aready = 1'b0;
    #1;
    n_checks++; if (ord_full !== 1'b0 || ord_valid !== 1'b1) begin n_fail++; $display("FAIL pp_not_full: full=%b valid=%b want 0/1", ord_full, ord_valid); end
    n = 0;
    ord_pop = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (ord_valid) n++;
      cycle();
    end
    ord_pop = 1'b0;
    n_checks++; if (n != 3) begin n_fail++; $display("FAIL pp_count: got %0d want 3", n); end
    n_checks++; if (ord_valid !== 1'b0 || ord_full !== 1'b0) begin n_fail++; $display("FAIL pp_empty_pop: valid=%b full=%b want 0/0", ord_valid, ord_full); end
    req      = 4'b0001;
    s_aready = 1'b1;
    cycle();
    cycle();
    req      = 4'b0000;
    s_aready = 1'b0;
    #1;
    n_checks++; if (ord_valid !== 1'b1 || ord_idx !== 2'd0 || ord_full !== 1'b0) begin
      n_fail++; $display("FAIL pp_after_underflow: valid=%b idx=%0d full=%b want 1/0/0", ord_valid, ord_idx, ord_full);
    end
    ord_pop = 1'b1;
    cycle();
    ord_pop = 1'b0;
    #1;
    n_checks++; if (ord_valid !== 1'b0) begin n_fail++; $display("FAIL pp_single_pop: got %b want 0", ord_valid); end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    req      = 4'b0010;
    s_aready = 1'b1;
    cycle();
    cycle();
    req      = 4'b1000;
    s_aready = 1'b0;
    cycle();
    n_checks++; if (grant !== 4'b1000 || ord_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: grant=%b valid=%b want 1000/1", grant, ord_valid); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (grant !== 4'b0000 || s_avalid !== 1'b0 || ord_valid !== 1'b0 || grant_idx !== 2'd0) begin
      n_fail++; $display("FAIL mid_async_clear: grant=%b avalid=%b valid=%b gidx=%0d want 0000/0/0/0", grant, s_avalid, ord_valid, grant_idx);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 4'b1111;
    cycle();
    n_checks++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_reset: got %b want 0001", grant); end
  endtask

  task automatic test_random();
    logic [3:0] eg;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom & 32'hF);
      if (mdl_busy) req = req | (4'b0001 << mdl_gnt);
      s_aready = 1'($urandom % 2);
      ord_pop  = ((c / 50) % 2 == 1) ? ($urandom % 8 == 0) : 1'($urandom % 2);
      #1;
      eg = mdl_busy ? (4'b0001 << mdl_gnt) : 4'b0000;
      n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b want %b", c, grant, eg); end
      n_checks++; if (grant_idx !== (mdl_busy ? 2'(mdl_gnt) : 2'd0)) begin n_fail++; $display("FAIL rnd_gidx c%0d: got %0d want %0d", c, grant_idx, mdl_busy ? mdl_gnt : 0); end
      n_checks++; if (s_avalid !== mdl_busy) begin n_fail++; $display("FAIL rnd_avalid c%0d: got %b want %b", c, s_avalid, mdl_busy); end
      n_checks++; if (m_aready !== (s_aready ? eg : 4'b0000)) begin n_fail++; $display("FAIL rnd_maready c%0d: got %b want %b", c, m_aready, s_aready ? eg : 4'b0000); end
      n_checks++; if (ord_valid !== (mdl_q.size() > 0) || ord_full !== (mdl_q.size() == DEPTH)) begin
        n_fail++; $display("FAIL rnd_ord_flags c%0d: valid=%b full=%b size=%0d", c, ord_valid, ord_full, mdl_q.size());
      end
      if (mdl_q.size() > 0) begin
        n_checks++; if (ord_idx !== 2'(mdl_q[0])) begin n_fail++; $display("FAIL rnd_ord_idx c%0d: got %0d want %0d", c, ord_idx, mdl_q[0]); end
      end
      cycle();
    end
    req      = 4'b0000;
    s_aready = 1'b0;
    ord_pop  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_fifo_full();
    test_push_pop();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
